// File: rtl/aes_pipe_batch_driver.sv
`default_nettype none
// ============================================================================
// Module   : aes_pipe_batch_driver
// Purpose  : Writes a counter-derived plaintext batch into the AES core input
//            FIFO, fires encrypt go, drains and XOR-digests the ciphertexts.
// Options  : AES_DRIVER_TIMEOUT_EN compiles in the DRAIN watchdog (err_code 3)
// Revision : 1.0
// ============================================================================
module aes_pipe_batch_driver #(
   parameter int pMAX_COUNT = 512,
   parameter int pTIMEOUT   = 4096
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [15:0]   count,
   input  logic [127:0]  pt_base,
   output logic          busy,
   output logic          done,
   output logic          error,
   output logic [1:0]    err_code,
   output logic [127:0]  digest,
   output logic [127:0]  last_ct,
   output logic [15:0]   rd_count,
   output logic          pipe_write_data,
   output logic [127:0]  pipe_data_i,
   output logic          pipe_encrypt_go,
   output logic          pipe_read_data,
   input  logic [127:0]  pipe_data_o,
   input  logic          pipe_fifo_out_empty,
   input  logic [3:0]    pipe_fifo_errors,
   output logic          pipe_clear_fifo_errors
);

   localparam logic [16:0] c_MAX_COUNT   = 17'(pMAX_COUNT);
   localparam logic [1:0]  c_ERR_FIFO    = 2'd1;
   localparam logic [1:0]  c_ERR_COUNT   = 2'd2;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLEAR = 3'd1,
      S_WRITE = 3'd2,
      S_GO    = 3'd3,
      S_DRAIN = 3'd4,
      S_DONE  = 3'd5,
      S_ERROR = 3'd6
   } state_t;

   state_t        state_q, state_d;
   logic [15:0]   cnt_q, cnt_d;
   logic [15:0]   wr_cnt_q, wr_cnt_d;
   logic [15:0]   rd_count_q, rd_count_d;
   logic [127:0]  data_q, data_d;
   logic [127:0]  digest_q, digest_d;
   logic [127:0]  last_ct_q, last_ct_d;
   logic [1:0]    err_code_q, err_code_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          error_q, error_d;
   logic          wr_q, wr_d;
   logic          go_q, go_d;
   logic          rd_q, rd_d;
   logic          clr_q, clr_d;
   logic          cap_q, cap_d;

   logic          w_count_ok;
   logic          w_fifo_err;
   logic          w_more_reads;

`ifdef AES_DRIVER_TIMEOUT_EN
   localparam logic [1:0] c_ERR_TIMEOUT = 2'd3;
   logic [15:0]   wd_q, wd_d;
   logic          tick_q, tick_d;
   logic          w_timeout;

   assign w_timeout = (wd_q == 16'(pTIMEOUT));
`else
   logic          w_unused_timeout;
   assign w_unused_timeout = ^pTIMEOUT;
`endif

   assign w_count_ok   = (count != 16'd0) && ({1'b0, count} <= c_MAX_COUNT);
   assign w_fifo_err   = |pipe_fifo_errors;
   // Reads already committed = captured + the one whose data arrives this cycle.
   assign w_more_reads = (({1'b0, rd_count_q} + {16'd0, cap_q}) < {1'b0, cnt_q});

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      wr_cnt_d   = wr_cnt_q;
      rd_count_d = rd_count_q;
      data_d     = data_q;
      digest_d   = digest_q;
      last_ct_d  = last_ct_q;
      err_code_d = err_code_q;
      done_d     = 1'b0;
      wr_d       = 1'b0;
      go_d       = 1'b0;
      rd_d       = 1'b0;
      clr_d      = 1'b0;
      cap_d      = rd_q;

      case (state_q)
         S_IDLE, S_ERROR: begin
            if (start) begin
               if (w_count_ok) begin
                  state_d    = S_CLEAR;
                  clr_d      = 1'b1;
                  cnt_d      = count;
                  data_d     = pt_base;
                  digest_d   = '0;
                  last_ct_d  = '0;
                  rd_count_d = '0;
                  err_code_d = 2'd0;
               end else begin
                  state_d    = S_ERROR;
                  err_code_d = c_ERR_COUNT;
               end
            end
         end
         S_CLEAR: begin
            state_d  = S_WRITE;
            wr_d     = 1'b1;
            wr_cnt_d = '0;
         end
         S_WRITE: begin
            if (w_fifo_err) begin
               state_d    = S_ERROR;
               err_code_d = c_ERR_FIFO;
            end else begin
               wr_cnt_d = wr_cnt_q + 16'd1;
               data_d   = data_q + 128'd1;
               if (wr_cnt_d == cnt_q) begin
                  state_d = S_GO;
                  go_d    = 1'b1;
               end else begin
                  wr_d = 1'b1;
               end
            end
         end
         S_GO: begin
            if (w_fifo_err) begin
               state_d    = S_ERROR;
               err_code_d = c_ERR_FIFO;
            end else begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (w_fifo_err) begin
               state_d    = S_ERROR;
               err_code_d = c_ERR_FIFO;
            end else begin
               if (cap_q) begin
                  digest_d   = digest_q ^ pipe_data_o;
                  last_ct_d  = pipe_data_o;
                  rd_count_d = rd_count_q + 16'd1;
                  if (rd_count_d == cnt_q) begin
                     state_d = S_DONE;
                     done_d  = 1'b1;
                  end
               end
`ifdef AES_DRIVER_TIMEOUT_EN
               else if (w_timeout) begin
                  state_d    = S_ERROR;
                  err_code_d = c_ERR_TIMEOUT;
               end
`endif
               // Skipping the cycle after a strobe lets the empty flag settle.
               if ((state_d == S_DRAIN) && !rd_q && !pipe_fifo_out_empty && w_more_reads) begin
                  rd_d = 1'b1;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      error_d = (state_d == S_ERROR);
      busy_d  = (state_d == S_CLEAR) || (state_d == S_WRITE) ||
                (state_d == S_GO)    || (state_d == S_DRAIN);
   end

`ifdef AES_DRIVER_TIMEOUT_EN
   always_comb begin
      wd_d   = wd_q;
      tick_d = tick_q;
      if ((state_q == S_GO) || ((state_q == S_DRAIN) && cap_q)) begin
         wd_d   = '0;
         tick_d = 1'b0;
      end else if (state_q == S_DRAIN) begin
         tick_d = ~tick_q;
         if (tick_q) begin
            wd_d = wd_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_q   <= '0;
         tick_q <= 1'b0;
      end else begin
         wd_q   <= wd_d;
         tick_q <= tick_d;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         wr_cnt_q   <= '0;
         rd_count_q <= '0;
         data_q     <= '0;
         digest_q   <= '0;
         last_ct_q  <= '0;
         err_code_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         wr_q       <= 1'b0;
         go_q       <= 1'b0;
         rd_q       <= 1'b0;
         clr_q      <= 1'b0;
         cap_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         wr_cnt_q   <= wr_cnt_d;
         rd_count_q <= rd_count_d;
         data_q     <= data_d;
         digest_q   <= digest_d;
         last_ct_q  <= last_ct_d;
         err_code_q <= err_code_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         error_q    <= error_d;
         wr_q       <= wr_d;
         go_q       <= go_d;
         rd_q       <= rd_d;
         clr_q      <= clr_d;
         cap_q      <= cap_d;
      end
   end

   assign busy                   = busy_q;
   assign done                   = done_q;
   assign error                  = error_q;
   assign err_code               = err_code_q;
   assign digest                 = digest_q;
   assign last_ct                = last_ct_q;
   assign rd_count               = rd_count_q;
   assign pipe_write_data        = wr_q;
   assign pipe_data_i            = data_q;
   assign pipe_encrypt_go        = go_q;
   assign pipe_read_data         = rd_q;
   assign pipe_clear_fifo_errors = clr_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_pipe_batch_driver.sv
`default_nettype none
// Bench for aes_pipe_batch_driver: a FIFO/latency stand-in for the AES core with a
// toy word-swap cipher, a batch-level reference model and literal pins.
module tb_aes_pipe_batch_driver;
`ifdef AES_DRIVER_TIMEOUT_EN
   localparam int TMO = 64;
`else
   localparam int TMO = 4096;
`endif
   localparam int           LAT  = 6;
   localparam logic [127:0] K    = 128'h0123456789abcdef_fedcba9876543210;
   localparam logic [127:0] FIPS = 128'h00112233445566778899aabbccddeeff;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [15:0]   count = '0;
   logic [127:0]  pt_base = '0;
   logic          busy, done, error;
   logic [1:0]    err_code;
   logic [127:0]  digest, last_ct, pipe_data_i;
   logic [15:0]   rd_count;
   logic          pipe_write_data, pipe_encrypt_go, pipe_read_data, pipe_clear_fifo_errors;
   logic [127:0]  pipe_data_o = '0;
   logic          empty_r = 1'b1;
   logic          hold_empty = 1'b0;
   logic          fifo_empty;
   logic [3:0]    err_inj = '0;

   assign fifo_empty = empty_r | hold_empty;

   aes_pipe_batch_driver #(.pMAX_COUNT(512), .pTIMEOUT(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .count(count), .pt_base(pt_base),
      .busy(busy), .done(done), .error(error), .err_code(err_code),
      .digest(digest), .last_ct(last_ct), .rd_count(rd_count),
      .pipe_write_data(pipe_write_data), .pipe_data_i(pipe_data_i),
      .pipe_encrypt_go(pipe_encrypt_go), .pipe_read_data(pipe_read_data),
      .pipe_data_o(pipe_data_o), .pipe_fifo_out_empty(fifo_empty),
      .pipe_fifo_errors(err_inj), .pipe_clear_fifo_errors(pipe_clear_fifo_errors)
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_chk  = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic logic [127:0] toy(input logic [127:0] x);
      return {x[63:0], x[127:64]} ^ K;
   endfunction

   // ---------------- AES core stand-in ----------------
   typedef struct { logic [127:0] d; int t; } pend_t;
   logic [127:0] in_q[$];
   logic [127:0] out_q[$];
   pend_t        pipe_q[$];
   pend_t        p_tmp;
   bit           engaged = 1'b0;
   int           cyc = 0;
   int           underflow = 0;

   always @(posedge clk) begin
      cyc++;
      if (pipe_clear_fifo_errors) begin
         in_q.delete(); out_q.delete(); pipe_q.delete(); engaged = 1'b0;
      end
      if (pipe_write_data) in_q.push_back(pipe_data_i);
      if (pipe_encrypt_go) engaged = 1'b1;
      if (engaged && in_q.size() > 0) begin
         p_tmp.d = toy(in_q.pop_front());
         p_tmp.t = cyc + LAT;
         pipe_q.push_back(p_tmp);
      end
      while (pipe_q.size() > 0 && pipe_q[0].t <= cyc) begin
         p_tmp = pipe_q.pop_front();
         out_q.push_back(p_tmp.d);
      end
      if (pipe_read_data) begin
         if (out_q.size() == 0) underflow++;
         else pipe_data_o <= out_q.pop_front();
      end
      empty_r <= (out_q.size() == 0);
   end

   // ---------------- batch model + per-cycle compare ----------------
   logic [127:0] m_base = '0;
   logic [127:0] m_dig  = '0;
   int           m_n = 0, m_k = 0, m_wi = 0, m_done_cnt = 0;

   always @(negedge clk) begin
      if (rst_n) begin
         if (pipe_write_data | pipe_encrypt_go | pipe_read_data | pipe_clear_fifo_errors)
            chk("strobe_needs_busy", 128'(busy), 128'd1);
         if (pipe_write_data) begin
            chk("wr_in_range", 128'(m_wi < m_n), 128'd1);
            chk("wr_data", pipe_data_i, m_base + 128'(m_wi));
            m_wi++;
         end
         if ((busy || done) && rd_count != 16'(m_k)) begin
            if (m_k < m_n && rd_count == 16'(m_k + 1)) begin
               m_dig = m_dig ^ toy(m_base + 128'(m_k));
               m_k++;
               chk("digest_prefix", digest, m_dig);
               chk("last_ct_prefix", last_ct, toy(m_base + 128'(m_k - 1)));
               chk("done_with_final", 128'(done), 128'(m_k == m_n));
            end else begin
               chk("rd_count_step", 128'(rd_count), 128'(m_k + 1));
            end
         end
         if (done) begin
            m_done_cnt++;
            chk("done_after_all", 128'(m_k), 128'(m_n));
         end
      end
   end

   task automatic setup_model(input logic [127:0] b, input logic [15:0] n);
      m_base = b; m_n = int'(n); m_k = 0; m_dig = '0; m_wi = 0;
   endtask

   task automatic run_batch(input logic [127:0] b, input logic [15:0] n, input bit poke,
                            output logic [127:0] dig, output logic [127:0] lct);
      int wr_seen, c, d0;
      logic [127:0] ed, el;
      @(posedge clk); #1;
      start = 1'b1; count = n; pt_base = b;
      setup_model(b, n);
      d0 = m_done_cnt;
      @(posedge clk); #1;
      start = 1'b0;
      chk("clear_pulse", 128'({busy, pipe_clear_fifo_errors, pipe_write_data}), 128'(3'b110));
      wr_seen = 0;
      for (int i = 0; i < int'(n); i++) begin
         @(posedge clk); #1;
         if (pipe_write_data) wr_seen++;
      end
      chk("write_cycles", 128'(wr_seen), 128'(n));
      @(posedge clk); #1;
      chk("go_pulse", 128'({pipe_encrypt_go, pipe_write_data}), 128'(2'b10));
      c = 0;
      while (!done && c < 4 * int'(n) + 200) begin
         @(posedge clk); #1;
         c++;
         if (poke) begin
            start = (c == 4);
            count = 16'd0;
         end
      end
      start = 1'b0;
      chk("done_seen", 128'(done), 128'd1);
      ed = '0;
      for (int i = 0; i < int'(n); i++) ed = ed ^ toy(b + 128'(i));
      el = toy(b + 128'(n - 16'd1));
      chk("final_digest", digest, ed);
      chk("final_last_ct", last_ct, el);
      chk("final_rd_count", 128'(rd_count), 128'(n));
      chk("final_no_error", 128'({error, err_code, busy}), 128'd0);
      dig = digest;
      lct = last_ct;
      @(posedge clk); #1;
      chk("done_one_cycle", 128'({done, busy}), 128'd0);
      chk("done_count", 128'(m_done_cnt - d0), 128'd1);
      chk("no_underflow", 128'(underflow), 128'd0);
   endtask

   task automatic run_illegal(input logic [15:0] n);
      int w;
      w = 0;
      @(posedge clk); #1;
      start = 1'b1; count = n;
      @(posedge clk); #1;
      start = 1'b0;
      chk("illegal_error", 128'({error, err_code, busy}), 128'(4'b1100));
      for (int i = 0; i < 6; i++) begin
         if (pipe_write_data | pipe_clear_fifo_errors | pipe_encrypt_go) w++;
         @(posedge clk); #1;
      end
      chk("illegal_no_strobes", 128'(w), 128'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout: got still running expected finished");
      $fatal(1, "bench time limit");
   end

   initial begin
      logic [127:0] d, l, dg;
      logic [15:0]  rc;
      int c, r, d0;

      repeat (3) @(posedge clk);
      #1;
      chk("reset_ctrl", 128'({busy, done, error, err_code, pipe_write_data, pipe_encrypt_go,
                              pipe_read_data, pipe_clear_fifo_errors, rd_count}), 128'd0);
      chk("reset_data", digest | last_ct | pipe_data_i, 128'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_batch(FIPS, 16'd1, 1'b0, d, l);
      chk("pin_single_digest", d, 128'h89baefdc45762310_fecd98ab32015467);
      chk("pin_single_last", l, 128'h89baefdc45762310_fecd98ab32015467);

      run_batch({128{1'b1}}, 16'd2, 1'b0, d, l);
      chk("pin_wrap_digest", d, {128{1'b1}});
      chk("pin_wrap_last", l, K);

      run_batch(128'h0000_0000_0000_0000_ffff_ffff_ffff_fffd, 16'd5, 1'b1, d, l);

      run_illegal(16'd0);
      run_illegal(16'd513);
      run_batch(128'h1234, 16'd3, 1'b0, d, l);

      run_batch(128'h1000, 16'd512, 1'b0, d, l);
      run_batch({128{1'b1}} - 128'd100, 16'd512, 1'b0, d, l);

      // FIFO error injected mid-DRAIN
      @(posedge clk); #1;
      start = 1'b1; count = 16'd8; pt_base = 128'h77;
      setup_model(128'h77, 16'd8);
      @(posedge clk); #1;
      start = 1'b0;
      c = 0;
      while (!pipe_read_data && c < 200) begin
         @(posedge clk); #1;
         c++;
      end
      chk("saw_drain_read", 128'(pipe_read_data), 128'd1);
      @(posedge clk); #1;
      err_inj = 4'b0100;
      @(posedge clk); #1;
      err_inj = 4'b0000;
      chk("fifo_err_state", 128'({error, err_code, busy, pipe_read_data, pipe_write_data,
                                  pipe_encrypt_go}), 128'(7'b1010000));
      rc = rd_count;
      dg = digest;
      r = 0;
      repeat (5) begin
         @(posedge clk); #1;
         if (pipe_read_data) r++;
      end
      chk("err_hold", 128'({error, err_code, rd_count}), 128'({1'b1, 2'd1, rc}));
      chk("err_hold_digest", digest, dg);
      chk("err_no_reads", 128'(r), 128'd0);

      run_batch(128'hfeed, 16'd4, 1'b0, d, l);

      // reset pulled mid-WRITE
      @(posedge clk); #1;
      start = 1'b1; count = 16'd20; pt_base = 128'habc0;
      setup_model(128'habc0, 16'd20);
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("mid_write", 128'(pipe_write_data), 128'd1);
      d0 = m_done_cnt;
      rst_n = 1'b0;
      #1;
      chk("rst_ctrl", 128'({busy, done, error, err_code, pipe_write_data, pipe_encrypt_go,
                            pipe_read_data, pipe_clear_fifo_errors, rd_count}), 128'd0);
      chk("rst_data", digest | last_ct | pipe_data_i, 128'd0);
      @(negedge clk);
      rst_n = 1'b1;
      r = 0;
      repeat (8) begin
         @(posedge clk); #1;
         if (busy | done) r++;
      end
      chk("rst_stays_idle", 128'(r), 128'd0);
      chk("rst_no_done", 128'(m_done_cnt - d0), 128'd0);

      run_batch(128'h5a5a, 16'd4, 1'b0, d, l);

`ifdef AES_DRIVER_TIMEOUT_EN
      hold_empty = 1'b1;
      @(posedge clk); #1;
      start = 1'b1; count = 16'd4; pt_base = 128'h9;
      setup_model(128'h9, 16'd4);
      @(posedge clk); #1;
      start = 1'b0;
      c = 0;
      while (!pipe_encrypt_go && c < 50) begin
         @(posedge clk); #1;
         c++;
      end
      c = 0;
      while (!error && c < 400) begin
         @(posedge clk); #1;
         c++;
      end
      chk("timeout_err", 128'({error, err_code}), 128'(3'b111));
      chk("timeout_window", 128'(c >= 128 && c <= 131), 128'd1);
      hold_empty = 1'b0;
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
